// File: rtl/logic_op_arbiter.sv
// logic_op_arbiter: two requesters time-share one K-bit bitwise logic unit.
// An accepted operation is computed and registered into a single result slot.
// The slot is held until the consumer takes it. Grants alternate under
// contention through a one-bit priority pointer.
//
// Handshake (requester and result ports): a transfer happens on a rising
// clock edge where valid and ready are both 1. The ready signals never depend
// on the data being offered. A requester may withdraw valid at any time it is
// not being accepted. res_valid, res_data and res_id stay stable until the
// consumer transfers the result.
module logic_op_arbiter #(
  parameter int K = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [1:0]   req0_op,
  input  logic [K-1:0] req0_a,
  input  logic [K-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [1:0]   req1_op,
  input  logic [K-1:0] req1_a,
  input  logic [K-1:0] req1_b,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [K-1:0] res_data,
  output logic         res_id,
  output logic [7:0]   op_count,
  output logic         dbg_state
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic         prio;
  logic         grant;
  logic         any_valid;
  logic         accept;
  logic         consume;
  logic [1:0]   sel_op;
  logic [K-1:0] sel_a;
  logic [K-1:0] sel_b;
  logic [K-1:0] op_result;

  assign dbg_state = state;

  // State register: IDLE waits for a request, HOLD owns an unconsumed result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: leave IDLE on any accept, leave HOLD when the result is taken.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_valid) state_nxt = HOLD;
      HOLD:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs of the FSM: grant choice, the readies, and the accept and consume strobes.
  always_comb begin
    any_valid  = req0_valid | req1_valid;
    // A lone requester always wins. With both requesting, prio breaks the tie.
    grant      = (req0_valid & req1_valid) ? prio : (req1_valid & ~req0_valid);
    accept     = (state == IDLE) & any_valid;
    consume    = (state == HOLD) & res_ready;
    // Gating with rst_n keeps both readies low for the whole time reset is held.
    req0_ready = rst_n & accept & ~grant;
    req1_ready = rst_n & accept & grant;
  end

  // Operand mux followed by the shared bitwise unit. The result is exactly K bits wide.
  always_comb begin
    sel_op = grant ? req1_op : req0_op;
    sel_a  = grant ? req1_a  : req0_a;
    sel_b  = grant ? req1_b  : req0_b;
    case (sel_op)
      2'b00:   op_result = ~sel_a;
      2'b01:   op_result = sel_a & sel_b;
      2'b10:   op_result = sel_a | sel_b;
      default: op_result = sel_a ^ sel_b;
    endcase
  end

  // Result slot, priority pointer and the saturating completion counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= 1'b0;
      prio      <= 1'b0;
      op_count  <= 8'd0;
    end else begin
      if (accept) begin
        res_data  <= op_result;
        res_id    <= grant;
        res_valid <= 1'b1;
        prio      <= ~grant;
      end else if (consume) begin
        res_valid <= 1'b0;
        if (op_count != 8'hFF) op_count <= op_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_logic_op_arbiter.sv
// tb_logic_op_arbiter: randomized and directed stimulus. The outputs are
// checked every cycle against a behavioural model. The model keeps the
// pending results in an expected queue and applies the grant rules directly.
module tb_logic_op_arbiter;
  localparam int K = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0;
  logic         req0_ready;
  logic [1:0]   req0_op = '0;
  logic [K-1:0] req0_a = '0;
  logic [K-1:0] req0_b = '0;
  logic         req1_valid = 1'b0;
  logic         req1_ready;
  logic [1:0]   req1_op = '0;
  logic [K-1:0] req1_a = '0;
  logic [K-1:0] req1_b = '0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [K-1:0] res_data;
  logic         res_id;
  logic [7:0]   op_count;
  logic         dbg_state;

  int tests = 0;
  int errors = 0;

  // Model state: pending results as {id, data}, priority pointer, completion count
  logic [K:0] exp_q[$];
  bit         m_prio;
  int         m_count;

  logic_op_arbiter #(.K(K)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_id(res_id), .op_count(op_count), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [K-1:0] logic_op(input logic [1:0] op, input logic [K-1:0] a, input logic [K-1:0] b);
    case (op)
      2'd0:    return ~a;
      2'd1:    return a & b;
      2'd2:    return a | b;
      default: return a ^ b;
    endcase
  endfunction

  // -1: nobody requests, otherwise the index of the winning requester
  function automatic int pick(input bit v0, input bit v1, input bit p);
    if (v0 && v1) return int'(p);
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_prio  = 1'b0;
    m_count = 0;
  endtask

  // Drive one cycle of inputs at the falling edge, then compare all outputs
  // (registered ones reflect the earlier edges, readies reflect these inputs).
  // Finally advance the model by the coming rising edge.
  task automatic step(input bit v0, input logic [1:0] o0, input logic [K-1:0] a0, input logic [K-1:0] b0,
                      input bit v1, input logic [1:0] o1, input logic [K-1:0] a1, input logic [K-1:0] b1,
                      input bit rr);
    int w;
    bit busy;
    @(negedge clk);
    req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
    res_ready = rr;
    #1;
    busy = (exp_q.size() != 0);
    w = busy ? -1 : pick(v0, v1, m_prio);
    chk("req0_ready", 32'(req0_ready), 32'(w == 0));
    chk("req1_ready", 32'(req1_ready), 32'(w == 1));
    chk("res_valid", 32'(res_valid), 32'(busy));
    chk("dbg_state", 32'(dbg_state), 32'(busy));
    chk("op_count", 32'(op_count), 32'(m_count));
    if (busy) begin
      chk("res_data", 32'(res_data), 32'(exp_q[0][K-1:0]));
      chk("res_id", 32'(res_id), 32'(exp_q[0][K]));
    end
    if (w == 0) begin
      exp_q.push_back({1'b0, logic_op(o0, a0, b0)});
      m_prio = 1'b1;
    end else if (w == 1) begin
      exp_q.push_back({1'b1, logic_op(o1, a1, b1)});
      m_prio = 1'b0;
    end else if (busy && rr) begin
      void'(exp_q.pop_front());
      if (m_count < 255) m_count++;
    end
  endtask

  task automatic idle_step(input bit rr);
    step(1'b0, 2'd0, '0, '0, 1'b0, 2'd0, '0, '0, rr);
  endtask

  task automatic rand_step();
    step($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), K'($urandom), K'($urandom),
         $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), K'($urandom), K'($urandom),
         $urandom_range(0, 3) != 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [K-1:0] op_exp [4];
  logic         ids [$];

  initial begin
    op_exp[0] = 16'h5555; op_exp[1] = 16'h0A0A; op_exp[2] = 16'hAFAF; op_exp[3] = 16'hA5A5;

    // reset state
    do_reset();
    #1;
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);

    // single op from requester 0
    step(1'b1, 2'd0, 16'h00F0, 16'h0000, 1'b0, 2'd0, '0, '0, 1'b0);
    chk("single_ready0", 32'(req0_ready), 32'd1);
    idle_step(1'b1);
    chk("single_data", 32'(res_data), 32'hFF0F);
    chk("single_id", 32'(res_id), 32'd0);
    chk("single_valid", 32'(res_valid), 32'd1);
    idle_step(1'b1);

    // contention from prio = 0: grants alternate
    do_reset();
    ids.delete();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 2'd1, K'($urandom), K'($urandom), 1'b1, 2'd2, K'($urandom), K'($urandom), 1'b1);
      if (i % 2 == 1) ids.push_back(res_id);
    end
    chk("contend_cnt", 32'(ids.size()), 32'd4);
    chk("contend_id0", 32'(ids[0]), 32'd0);
    chk("contend_id1", 32'(ids[1]), 32'd1);
    chk("contend_id2", 32'(ids[2]), 32'd0);
    chk("contend_id3", 32'(ids[3]), 32'd1);
    idle_step(1'b1);

    // backpressure on a requester 1 result
    idle_step(1'b1);
    step(1'b0, 2'd0, '0, '0, 1'b1, 2'd3, 16'h1230, 16'h0004, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 2'($urandom_range(0, 3)), K'($urandom), K'($urandom),
           1'b1, 2'($urandom_range(0, 3)), K'($urandom), K'($urandom), 1'b0);
      chk("bp_data", 32'(res_data), 32'h1234);
      chk("bp_id", 32'(res_id), 32'd1);
      chk("bp_ready0", 32'(req0_ready), 32'd0);
      chk("bp_ready1", 32'(req1_ready), 32'd0);
    end
    idle_step(1'b1);
    idle_step(1'b0);
    chk("bp_count", 32'(op_count), 32'd5);

    // every opcode on fixed operands
    for (int op = 0; op < 4; op++) begin
      step(1'b1, 2'(op), 16'hAAAA, 16'h0F0F, 1'b0, 2'd0, '0, '0, 1'b0);
      idle_step(1'b1);
      chk("opcode_data", 32'(res_data), 32'(op_exp[op]));
    end

    // randomized traffic
    for (int i = 0; i < 2000; i++) rand_step();

    // asynchronous reset while a result is held
    if (exp_q.size() == 0) step(1'b1, 2'd2, 16'h0F00, 16'h00F0, 1'b0, 2'd0, '0, '0, 1'b0);
    idle_step(1'b0);
    chk("pre_rst_valid", 32'(res_valid), 32'd1);
    #2;
    req0_valid = 1'b1; req1_valid = 1'b1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_valid", 32'(res_valid), 32'd0);
    chk("arst_data", 32'(res_data), 32'd0);
    chk("arst_count", 32'(op_count), 32'd0);
    chk("arst_ready0", 32'(req0_ready), 32'd0);
    chk("arst_ready1", 32'(req1_ready), 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    step(1'b1, 2'd1, 16'hFFFF, 16'h00FF, 1'b1, 2'd1, 16'hFFFF, 16'hFF00, 1'b1);
    chk("post_rst_grant0", 32'(req0_ready), 32'd1);
    idle_step(1'b1);
    chk("post_rst_data", 32'(res_data), 32'h00FF);

    // saturation: 260 consumed operations from a zero count
    do_reset();
    for (int i = 0; i < 260; i++) begin
      step(1'b1, 2'($urandom_range(0, 3)), K'($urandom), K'($urandom), 1'b0, 2'd0, '0, '0, 1'b1);
      idle_step(1'b1);
    end
    idle_step(1'b0);
    chk("sat_count", 32'(op_count), 32'd255);
    for (int i = 0; i < 40; i++) rand_step();
    idle_step(1'b1);
    idle_step(1'b0);
    chk("sat_hold", 32'(op_count), 32'd255);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  // time bound so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $display("[TB] %0d tests run, %0d failed", tests, errors + 1);
    $finish;
  end
endmodule
